// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between an
// instruction-fetch port (read only) and a data-memory port (load/store).
// DM wins contention unless IF has already lost MAX_DM_BURST times in a row.
// The request path is purely combinational; only the starvation counter and
// the read-response owner are registered.
module mem_port_arbiter #(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_DM_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          stall_if,
    output logic          stall_dm,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // Counter must be able to hold MAX_DM_BURST itself; keep at least one bit.
    localparam int unsigned CW = (MAX_DM_BURST < 1) ? 1 : $clog2(MAX_DM_BURST + 1);

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_IF   = 2'd1,
        RD_DM   = 2'd2
    } owner_e;

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    owner_e        owner_q, owner_d;
    logic          starved_c;
    logic          if_gnt_c, dm_gnt_c;

    // Arbitration: DM by default under contention, IF once its wait budget is spent.
    always_comb begin
        starved_c = (starve_cnt_q == CW'(MAX_DM_BURST));
        if_gnt_c  = if_req & (~dm_req | starved_c);
        dm_gnt_c  = dm_req & ~if_gnt_c;
    end

    // Grant and stall outputs.
    always_comb begin
        if_gnt   = if_gnt_c;
        dm_gnt   = dm_gnt_c;
        stall_if = if_req & ~if_gnt_c;
        stall_dm = dm_req & ~dm_gnt_c;
    end

    // RAM command mux: granted port drives the RAM, idle cycles drive zeros.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (if_gnt_c) begin
            ram_en   = 1'b1;
            ram_addr = if_addr;
        end else if (dm_gnt_c) begin
            ram_en    = 1'b1;
            ram_we    = dm_we;
            ram_addr  = dm_addr;
            ram_wdata = dm_wdata;
        end
    end

    // Next starvation count and next read-response owner.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        owner_d      = RD_NONE;
        if (!if_req || if_gnt_c) begin
            starve_cnt_d = '0;
        end else if (dm_gnt_c && !starved_c) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
        if (if_gnt_c) begin
            owner_d = RD_IF;
        end else if (dm_gnt_c && !dm_we) begin
            owner_d = RD_DM;
        end
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            owner_q      <= RD_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    // Read response steering: data is only presented to the port that owns it.
    always_comb begin
        if_rvalid = (owner_q == RD_IF);
        dm_rvalid = (owner_q == RD_DM);
        if_rdata  = if_rvalid ? ram_rdata : '0;
        dm_rdata  = dm_rvalid ? ram_rdata : '0;
    end

endmodule
